axi_read_arbiter: RTL

- Shares one AXI read port (AR + R channels) between NUM_MASTERS requesters.
- Arbitrates AR requests round-robin and prefixes the winner's index onto ARID.
- Routes R beats back by the ARID prefix.
- Enforces a per-master outstanding-burst limit.
- Sits between the master-side agents/DUT ports and the single downstream slave read interface.

---
 rtl/axi_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/axi_read_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Package : axi_pkg
//  Shared AXI widths, burst/response encodings and read-arbiter FSM states.
//  Rev     : 1.0  initial release
// ============================================================================
package axi_pkg;

   localparam int ID_WIDTH   = 4;
   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      FIXED = 2'd0,
      INCR  = 2'd1,
      WRAP  = 2'd2
   } burst_t;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } resp_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } ar_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arbiter
//  Combinational round-robin pick: first request at or above ptr, with wrap.
//  Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   logic [IDX_W-1:0] w_j;

   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      w_j   = '0;
      for (int k = 0; k < N; k++) begin
         w_j = IDX_W'((int'(ptr) + k) % N);
         if (!valid && req[w_j]) begin
            grant[w_j] = 1'b1;
            idx        = w_j;
            valid      = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : axi_read_arbiter
//  Shares one AXI read port among NUM_MASTERS requesters; RR on AR, ID routing on R.
//  Rev     : 1.0  initial release
// ============================================================================
module axi_read_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int ID_WIDTH    = axi_pkg::ID_WIDTH,
   parameter int ADDR_WIDTH  = axi_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH  = axi_pkg::DATA_WIDTH,
   parameter int MAX_OUTST   = 4,
   parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic                              aclk,
   input  logic                              aresetn,
   input  logic [NUM_MASTERS*ID_WIDTH-1:0]   s_arid,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_araddr,
   input  logic [NUM_MASTERS*8-1:0]          s_arlen,
   input  logic [NUM_MASTERS*3-1:0]          s_arsize,
   input  logic [NUM_MASTERS*2-1:0]          s_arburst,
   input  logic [NUM_MASTERS-1:0]            s_arvalid,
   output logic [NUM_MASTERS-1:0]            s_arready,
   output logic [ID_WIDTH-1:0]               s_rid,
   output logic [DATA_WIDTH-1:0]             s_rdata,
   output logic [1:0]                        s_rresp,
   output logic                              s_rlast,
   output logic [NUM_MASTERS-1:0]            s_rvalid,
   input  logic [NUM_MASTERS-1:0]            s_rready,
   output logic [ID_WIDTH+IDX_W-1:0]         m_arid,
   output logic [ADDR_WIDTH-1:0]             m_araddr,
   output logic [7:0]                        m_arlen,
   output logic [2:0]                        m_arsize,
   output logic [1:0]                        m_arburst,
   output logic                              m_arvalid,
   input  logic                              m_arready,
   input  logic [ID_WIDTH+IDX_W-1:0]         m_rid,
   input  logic [DATA_WIDTH-1:0]             m_rdata,
   input  logic [1:0]                        m_rresp,
   input  logic                              m_rlast,
   input  logic                              m_rvalid,
   output logic                              m_rready,
   output logic                              decode_err
);

   import axi_pkg::*;

   localparam int CNT_W = $clog2(MAX_OUTST + 1);
   localparam int RID_W = ID_WIDTH + IDX_W;

   ar_state_t                r_state;
   ar_state_t                w_state_nxt;
   logic [IDX_W-1:0]         r_ptr;
   logic [IDX_W-1:0]         r_win;
   logic [NUM_MASTERS-1:0]   w_elig;
   logic [NUM_MASTERS-1:0]   w_gnt;
   logic [IDX_W-1:0]         w_gnt_idx;
   logic                     w_gnt_vld;
   logic                     w_load;
   logic                     w_accept;
   logic [ID_WIDTH-1:0]      w_sel_id;
   logic [ADDR_WIDTH-1:0]    w_sel_addr;
   logic [7:0]               w_sel_len;
   logic [2:0]               w_sel_size;
   logic [1:0]               w_sel_burst;
   logic [IDX_W-1:0]         w_ridx;
   logic                     w_ridx_ok;
   logic                     w_rlast_hs;

   rr_arbiter #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_rr (
      .req   (w_elig),
      .ptr   (r_ptr),
      .grant (w_gnt),
      .idx   (w_gnt_idx),
      .valid (w_gnt_vld)
   );

   // Ready is gated by aresetn so no grant pulse escapes while reset is held.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_accept    = 1'b0;
      s_arready   = '0;
      case (r_state)
         IDLE: begin
            if (w_gnt_vld && aresetn) begin
               s_arready   = w_gnt;
               w_load      = 1'b1;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (m_arready) begin
               w_accept    = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign m_arvalid = (r_state == ISSUE);

   always_comb begin
      w_sel_id    = '0;
      w_sel_addr  = '0;
      w_sel_len   = '0;
      w_sel_size  = '0;
      w_sel_burst = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (w_gnt[i]) begin
            w_sel_id    = s_arid[i*ID_WIDTH +: ID_WIDTH];
            w_sel_addr  = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_sel_len   = s_arlen[i*8 +: 8];
            w_sel_size  = s_arsize[i*3 +: 3];
            w_sel_burst = s_arburst[i*2 +: 2];
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_win     <= '0;
         m_arid    <= '0;
         m_araddr  <= '0;
         m_arlen   <= '0;
         m_arsize  <= '0;
         m_arburst <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_win     <= w_gnt_idx;
            m_arid    <= {w_gnt_idx, w_sel_id};
            m_araddr  <= w_sel_addr;
            m_arlen   <= w_sel_len;
            m_arsize  <= w_sel_size;
            m_arburst <= w_sel_burst;
         end
         if (w_accept) begin
            r_ptr <= (r_win == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_win + 1'b1;
         end
      end
   end

   // R routing: out-of-range prefixes are sunk so the slave never stalls on them.
   assign w_ridx    = m_rid[RID_W-1:ID_WIDTH];
   assign w_ridx_ok = ({1'b0, w_ridx} < (IDX_W + 1)'(NUM_MASTERS));

   always_comb begin
      s_rvalid = '0;
      m_rready = 1'b1;
      if (w_ridx_ok) begin
         s_rvalid[w_ridx] = m_rvalid;
         m_rready         = s_rready[w_ridx];
      end
   end

   assign s_rid      = m_rid[ID_WIDTH-1:0];
   assign s_rdata    = m_rdata;
   assign s_rresp    = m_rresp;
   assign s_rlast    = m_rlast;
   assign w_rlast_hs = m_rvalid && m_rready && m_rlast && w_ridx_ok;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         decode_err <= 1'b0;
      end else if (m_rvalid && !w_ridx_ok) begin
         decode_err <= 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;
      logic             w_inc;
      logic             w_dec;

      assign w_inc     = w_accept && (r_win == IDX_W'(i));
      assign w_dec     = w_rlast_hs && (w_ridx == IDX_W'(i));
      assign w_elig[i] = s_arvalid[i] && (r_cnt < CNT_W'(MAX_OUTST));

      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            r_cnt <= '0;
         end else if (w_inc && !w_dec) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (w_dec && !w_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
